// File: rtl/isa_pkg.sv
// Shared definitions for the ISA 8-bit I/O responder: bus widths, window size,
// FSM state encoding and the register/status byte selector.
package isa_pkg;

    localparam int unsigned ISA_ADDR_W   = 10;
    localparam int unsigned ISA_DATA_W   = 8;
    localparam int unsigned ISA_WIN_SIZE = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        IGNORE    = 3'd1,
        WR_ACTIVE = 3'd2,
        WR_COMMIT = 3'd3,
        RD_WAIT   = 3'd4,
        RD_DRIVE  = 3'd5
    } isa_state_t;

    // Offsets 0..3 map to the ctrl bytes, 4..7 to the status bytes.
    function automatic logic [ISA_DATA_W-1:0] isa_reg_byte(
        input logic [31:0] ctrl,
        input logic [31:0] status,
        input logic [2:0]  off
    );
        logic [31:0] src;
        src = off[2] ? status : ctrl;
        return src[{off[1:0], 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/isa_strobe_sync.sv
// Multi-flop synchronizer for an asynchronous active-low ISA strobe; resets to
// the inactive (high) level.
module isa_strobe_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe_n_i,
    output logic strobe_n_o
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            chain_q <= '1;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], strobe_n_i};
        end
    end

    assign strobe_n_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/isa_io_responder.sv
// ISA 8-bit I/O target: decodes an 8-byte window, holds four host-writable
// control bytes, returns control/status bytes on reads with IOCHRDY waits.
module isa_io_responder
    import isa_pkg::*;
#(
    parameter logic [ISA_ADDR_W-1:0] BASE_ADDR   = 10'h220,
    parameter int unsigned           READ_WAIT   = 2,
    parameter int unsigned           SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ISA_ADDR_W-1:0] sa,
    input  logic                  aen,
    input  logic                  iow_n,
    input  logic                  ior_n,
    input  logic [ISA_DATA_W-1:0] sd_in,
    output logic [ISA_DATA_W-1:0] sd_out,
    output logic                  sd_oe,
    output logic                  iochrdy,
    input  logic [31:0]           status_in,
    output logic [31:0]           ctrl_out,
    output logic                  wr_evt,
    output logic                  rd_evt,
    output logic [2:0]            evt_index,
    output logic                  bus_err
);

    localparam int unsigned CNT_W = (READ_WAIT < 2) ? 1 : $clog2(READ_WAIT);

    logic ior_sync_n, iow_sync_n;
    logic iors, iows, hit;

    isa_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ior_sync (
        .clk        (clk),
        .reset      (reset),
        .strobe_n_i (ior_n),
        .strobe_n_o (ior_sync_n)
    );

    isa_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_iow_sync (
        .clk        (clk),
        .reset      (reset),
        .strobe_n_i (iow_n),
        .strobe_n_o (iow_sync_n)
    );

    assign iors = ~ior_sync_n;
    assign iows = ~iow_sync_n;
    assign hit  = (sa[9:3] == BASE_ADDR[9:3]) && !aen;

    isa_state_t            state_q, state_d;
    logic [2:0]            offset_q, offset_d;
    logic [ISA_DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           ctrl_q, ctrl_d;
    logic [ISA_DATA_W-1:0] sd_out_q, sd_out_d;
    logic                  sd_oe_q, sd_oe_d;
    logic                  iochrdy_q, iochrdy_d;
    logic                  wr_evt_q, wr_evt_d;
    logic                  rd_evt_q, rd_evt_d;
    logic                  bus_err_q, bus_err_d;
    logic [2:0]            evt_index_q, evt_index_d;
    logic                  both_q, both_d;

    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        ctrl_d      = ctrl_q;
        sd_out_d    = sd_out_q;
        sd_oe_d     = sd_oe_q;
        iochrdy_d   = 1'b1;
        wr_evt_d    = 1'b0;
        rd_evt_d    = 1'b0;
        bus_err_d   = 1'b0;
        evt_index_d = evt_index_q;
        both_d      = iors && iows;

        case (state_q)
            IDLE: begin
                // Conflict flags once on its leading edge, not every cycle it persists.
                if (iors && iows) begin
                    bus_err_d = !both_q;
                end else if (iors || iows) begin
                    if (!hit) begin
                        state_d = IGNORE;
                    end else begin
                        offset_d = sa[2:0];
                        if (iows) begin
                            state_d = WR_ACTIVE;
                        end else if (READ_WAIT > 0) begin
                            state_d   = RD_WAIT;
                            cnt_d     = CNT_W'(READ_WAIT - 1);
                            iochrdy_d = 1'b0;
                        end else begin
                            state_d     = RD_DRIVE;
                            sd_oe_d     = 1'b1;
                            sd_out_d    = isa_reg_byte(ctrl_q, status_in, sa[2:0]);
                            rd_evt_d    = 1'b1;
                            evt_index_d = sa[2:0];
                        end
                    end
                end
            end
            IGNORE: begin
                if (!iors && !iows) state_d = IDLE;
            end
            WR_ACTIVE: begin
                if (iows) wdata_d = sd_in;
                else      state_d = WR_COMMIT;
            end
            WR_COMMIT: begin
                if (!offset_q[2]) ctrl_d[{offset_q[1:0], 3'b000} +: 8] = wdata_q;
                wr_evt_d    = 1'b1;
                evt_index_d = offset_q;
                state_d     = IDLE;
            end
            RD_WAIT: begin
                if (!iors) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d     = RD_DRIVE;
                    sd_oe_d     = 1'b1;
                    sd_out_d    = isa_reg_byte(ctrl_q, status_in, offset_q);
                    rd_evt_d    = 1'b1;
                    evt_index_d = offset_q;
                end else begin
                    cnt_d     = cnt_q - CNT_W'(1);
                    iochrdy_d = 1'b0;
                end
            end
            RD_DRIVE: begin
                if (!iors) begin
                    sd_oe_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    sd_out_d = isa_reg_byte(ctrl_q, status_in, offset_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            offset_q    <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            ctrl_q      <= '0;
            sd_out_q    <= '0;
            sd_oe_q     <= 1'b0;
            iochrdy_q   <= 1'b1;
            wr_evt_q    <= 1'b0;
            rd_evt_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            evt_index_q <= '0;
            both_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            ctrl_q      <= ctrl_d;
            sd_out_q    <= sd_out_d;
            sd_oe_q     <= sd_oe_d;
            iochrdy_q   <= iochrdy_d;
            wr_evt_q    <= wr_evt_d;
            rd_evt_q    <= rd_evt_d;
            bus_err_q   <= bus_err_d;
            evt_index_q <= evt_index_d;
            both_q      <= both_d;
        end
    end

    assign sd_out    = sd_out_q;
    assign sd_oe     = sd_oe_q;
    assign iochrdy   = iochrdy_q;
    assign ctrl_out  = ctrl_q;
    assign wr_evt    = wr_evt_q;
    assign rd_evt    = rd_evt_q;
    assign bus_err   = bus_err_q;
    assign evt_index = evt_index_q;

endmodule
